// File: rtl/dds_freq_meter.sv
// dds_freq_meter: gated rising-edge counter and first-period meter for an
// asynchronous square wave (typically a DDS/DAC output fed back through a
// comparator). Results are used by the host to check and trim FWORD.
//
// Handshake: start_i is a one-cycle request and is accepted only in IDLE.
// busy_o is high while a measurement is in flight (SYNC or GATE). done_o
// pulses for exactly one cycle. The result outputs become valid in that
// same cycle and hold until the next done_o or reset.
module dds_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PER_W       = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sig_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic [PER_W-1:0] period_o,
  output logic             period_ovf_o,
  output logic             no_signal_o,
  output logic [1:0]       dbg_state_o
);

  // The gate counter must reach GATE_CYCLES even when CNT_W is narrow.
  // It is therefore at least CNT_W bits wide, and wider when needed.
  localparam int unsigned GATE_BITS = $clog2(GATE_CYCLES + 1);
  localparam int unsigned G_W       = (CNT_W > GATE_BITS) ? CNT_W : GATE_BITS;
  // Common width used to compare the gate count against the period ceiling.
  localparam int unsigned CMP_W     = (G_W > PER_W) ? G_W : PER_W;

  localparam logic [G_W-1:0]   GATE_END = G_W'(GATE_CYCLES);
  localparam logic [CMP_W-1:0] PER_MAX  = CMP_W'({PER_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Input synchronizer plus edge-detect register.
  logic s1_q, s2_q, s3_q;
  logic rise;

  // Working registers for the measurement in flight.
  logic [G_W-1:0]   g_q, g_d;        // SYNC timeout count, then gate count
  logic [CNT_W-1:0] cnt_q, cnt_d;    // counted rising edges
  logic [PER_W-1:0] per_q, per_d;    // captured first period
  logic             ovf_q, ovf_d;    // first period saturated
  logic             first_q, first_d;// first counted rise already captured
  logic             nosig_d;         // SYNC timed out this cycle
  logic [CMP_W-1:0] g_ext;

  // Published result registers.
  logic [CNT_W-1:0] edge_cnt_q;
  logic [PER_W-1:0] period_q;
  logic             period_ovf_q;
  logic             no_signal_q;

  // Two-flop synchronizer for the asynchronous pin, then one delay flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  // In SYNC, a rise takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_SYNC;
      S_SYNC: begin
        if (rise) begin
          state_d = S_GATE;
        end else if (g_q == GATE_END) begin
          state_d = S_DONE;
        end
      end
      S_GATE: if (g_q == GATE_END) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: status flags and the debug view of the state.
  always_comb begin
    busy_o      = (state_q == S_SYNC) || (state_q == S_GATE);
    done_o      = (state_q == S_DONE);
    dbg_state_o = state_q;
  end

  // Measurement datapath next-state logic.
  // In GATE, the gate counter holds g, and g starts at 1 on the first cycle after the opening edge.
  always_comb begin
    g_d     = g_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    nosig_d = 1'b0;
    g_ext   = CMP_W'(g_q);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          g_d     = '0;
          cnt_d   = '0;
          per_d   = '0;
          ovf_d   = 1'b0;
          first_d = 1'b0;
        end
      end
      S_SYNC: begin
        if (rise) begin
          // Opening edge: it starts the gate but is not itself counted.
          g_d = G_W'(1);
        end else begin
          g_d     = g_q + 1'b1;
          nosig_d = (g_q == GATE_END);
        end
      end
      S_GATE: begin
        g_d = g_q + 1'b1;
        if (rise) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!first_q) begin
            first_d = 1'b1;
            if (g_ext > PER_MAX) begin
              per_d = {PER_W{1'b1}};
              ovf_d = 1'b1;
            end else begin
              per_d = PER_W'(g_q);
              ovf_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Measurement datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      g_q     <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  // Publish results on entry to DONE so they are valid in the done_o cycle.
  // The next-state values are used so that a rise in the final gate cycle is included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_cnt_q   <= '0;
      period_q     <= '0;
      period_ovf_q <= 1'b0;
      no_signal_q  <= 1'b0;
    end else if (state_d == S_DONE) begin
      edge_cnt_q   <= cnt_d;
      period_q     <= per_d;
      period_ovf_q <= ovf_d;
      no_signal_q  <= nosig_d;
    end
  end

  assign edge_cnt_o   = edge_cnt_q;
  assign period_o     = period_q;
  assign period_ovf_o = period_ovf_q;
  assign no_signal_o  = no_signal_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Self-checking bench for dds_freq_meter.
// It uses a short gate (100 cycles) and a 4-bit period.
// A second instance with a 4-bit edge counter exercises saturation.
module tb_dds_freq_meter;

  localparam int GATE  = 100;
  localparam int EXP_W = 38;  // {edge_cnt[31:0], period[3:0], ovf, no_signal}

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sig_in = 1'b0;

  always #5 clk = ~clk;

  // DUT (CNT_W=32) outputs.
  logic        busy, done, ovf, nos;
  logic [31:0] cnt;
  logic [3:0]  per;
  logic [1:0]  st;

  // Saturation DUT (CNT_W=4) outputs.
  logic        busy_s, done_s, ovf_s, nos_s;
  logic [3:0]  cnt_s;
  logic [3:0]  per_s;
  logic [1:0]  st_s;

  dds_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .PER_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sig_in_i(sig_in),
    .busy_o(busy), .done_o(done), .edge_cnt_o(cnt), .period_o(per),
    .period_ovf_o(ovf), .no_signal_o(nos), .dbg_state_o(st)
  );

  dds_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .PER_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sig_in_i(sig_in),
    .busy_o(busy_s), .done_o(done_s), .edge_cnt_o(cnt_s), .period_o(per_s),
    .period_ovf_o(ovf_s), .no_signal_o(nos_s), .dbg_state_o(st_s)
  );

  // Square-wave generator: period gen_p cycles, with the first gen_h cycles high.
  // gen_p = 0 holds the input low and resets the phase.
  int gen_p = 0;
  int gen_h = 0;
  int ph    = 0;

  always @(negedge clk) begin
    if (gen_p == 0) begin
      sig_in = 1'b0;
      ph     = 0;
    end else begin
      sig_in = (ph < gen_h);
      ph     = (ph + 1 >= gen_p) ? 0 : ph + 1;
    end
  end

  // Scoreboard state.
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Park the input low briefly, then start a new waveform and let it settle.
  task automatic set_gen(input int p, input int h);
    gen_p = 0;
    repeat (5) @(negedge clk);
    gen_p = p;
    gen_h = h;
    repeat (30) @(negedge clk);
  endtask

  // Drive one measurement and score it against the expected result.
  // If e_lat > 0, the start-to-done latency is checked.
  // If extra_at > 0, a second start is pulsed that many cycles after acceptance.
  task automatic measure(input string tag, input int p, input int h,
                         input logic [31:0] e_cnt, input logic [3:0] e_per,
                         input logic e_ovf, input logic e_nos,
                         input int e_lat, input int extra_at);
    logic [EXP_W-1:0] e;
    logic [31:0] e_sat;
    logic busy_hole;
    int lat;
    set_gen(p, h);
    exp_q.push_back({e_cnt, e_per, e_ovf, e_nos});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy_after_start"}, busy, 1);
    lat = 0;
    busy_hole = 1'b0;
    for (int k = 1; k <= 400 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      start = (k == extra_at);
      if (done) lat = k;
      else if (!busy) busy_hole = 1'b1;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check_eq({tag, "_done_seen"}, (lat != 0), 1);
    if (lat != 0) begin
      e_sat = (e[37:6] > 32'd15) ? 32'd15 : e[37:6];
      if (e_lat > 0) check_eq({tag, "_latency"}, lat, e_lat);
      check_eq({tag, "_busy_held"}, busy_hole, 0);
      check_eq({tag, "_busy_at_done"}, busy, 0);
      check_eq({tag, "_edge_cnt"}, cnt, e[37:6]);
      check_eq({tag, "_period"}, per, e[5:2]);
      check_eq({tag, "_period_ovf"}, ovf, e[1]);
      check_eq({tag, "_no_signal"}, nos, e[0]);
      check_eq({tag, "_sat_done"}, done_s, 1);
      check_eq({tag, "_sat_edge_cnt"}, cnt_s, e_sat);
      check_eq({tag, "_sat_period"}, per_s, e[5:2]);
      check_eq({tag, "_sat_ovf"}, ovf_s, e[1]);
      @(posedge clk);
      #1;
      check_eq({tag, "_done_one_cycle"}, done, 0);
      check_eq({tag, "_result_held"}, cnt, e[37:6]);
    end
  endtask

  initial begin : main
    logic extra_done;
    int p, h;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_edge_cnt", cnt, 0);
    check_eq("rst_period", per, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_no_signal", nos, 0);
    check_eq("rst_state", st, 0);
    check_eq("rst_sat_edge_cnt", cnt_s, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Period-10 square wave.
    measure("sq10", 10, 5, 32'd10, 4'd10, 1'b0, 1'b0, 0, 0);
    // No signal: timeout after GATE+1 cycles.
    measure("nosig", 0, 0, 32'd0, 4'd0, 1'b0, 1'b1, GATE + 1, 0);
    // Period 20 saturates the 4-bit period.
    measure("sq20", 20, 10, 32'd5, 4'd15, 1'b1, 1'b0, 0, 0);
    // Second edge exactly at g=GATE is counted.
    measure("edge_g100", 100, 1, 32'd1, 4'd15, 1'b1, 1'b0, 0, 0);
    // Second edge at g=GATE+1 falls outside the gate.
    measure("edge_g101", 101, 1, 32'd0, 4'd0, 1'b0, 1'b0, 0, 0);

    // Start pulsed during GATE is dropped: one done only.
    measure("restart", 10, 5, 32'd10, 4'd10, 1'b0, 1'b0, 0, 30);
    extra_done = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      if (done) extra_done = 1'b1;
    end
    check_eq("restart_no_second_done", extra_done, 0);

    // Reset mid-GATE aborts without done and clears the outputs.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_edge_cnt", cnt, 0);
    check_eq("abort_period", per, 0);
    check_eq("abort_state", st, 0);
    @(negedge clk);
    rst = 1'b0;
    extra_done = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      if (done) extra_done = 1'b1;
    end
    check_eq("abort_no_done", extra_done, 0);
    @(negedge clk);
    measure("after_abort", 10, 5, 32'd10, 4'd10, 1'b0, 1'b0, 0, 0);

    // Period-2 wave: 50 edges; the 4-bit instance saturates at 15.
    measure("sq2", 2, 1, 32'd50, 4'd2, 1'b0, 1'b0, 0, 0);

    // Random periods that fit in the 4-bit period field.
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(3, 15);
      h = $urandom_range(1, p - 1);
      measure($sformatf("rand%0d_p%0d", i, p), p, h, 32'(GATE / p), 4'(p), 1'b0, 1'b0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
